// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry register process one bit per clock, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the sub port).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] s_q;
   logic             co_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] opb_d;
   logic             cin_d;
   logic             sum_d;
   logic             cout_d;

   // Operand B and carry-in as they are latched; subtraction becomes a + ~b + 1.
   always_comb begin
      opb_d = b;
      cin_d = ci;
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) begin
         opb_d = ~b;
         cin_d = 1'b1;
      end else begin
         opb_d = b;
         cin_d = ci;
      end
`endif
   end

   // The single full-adder cell; operands are shifted so bit 0 is always the current bit.
   always_comb begin
      sum_d  = opa_q[0] ^ opb_q[0] ^ carry_q;
      cout_d = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
   end

   // Control FSM, datapath shift registers and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         work_q  <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  opa_q   <= a;
                  opb_q   <= opb_d;
                  carry_q <= cin_d;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
               opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
               work_q  <= {sum_d, work_q[WIDTH-1:1]};
               carry_q <= cout_d;
               cnt_q   <= cnt_q + CW'(1);
               // carry_q here is the carry into the MSB, so overflow is its xor with carry-out.
               if (cnt_q == LAST_BIT) begin
                  s_q     <= {sum_d, work_q[WIDTH-1:1]};
                  co_q    <= cout_d;
                  ovf_q   <= carry_q ^ cout_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= RUN;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         ci = 1'b0;
   logic         sub = 1'b0;
   logic         busy, done, co, ovf;
   logic [W-1:0] s;

   int errors = 0;
   int checks = 0;
   logic [9:0] last_res = '0;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Returns {ovf, co, s} computed with plain arithmetic.
   function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                        input logic cv, input logic sv);
      logic [7:0] bb;
      logic       cc;
      logic [8:0] t;
      bb = sv ? ~bv : bv;
      cc = sv ? 1'b1 : cv;
      t = {1'b0, av} + {1'b0, bb} + {8'd0, cc};
      return {(av[7] == bb[7]) && (t[7] != av[7]), t[8], t[7:0]};
   endfunction

   // Issues one operation from a negedge and observes it; ends on a negedge after done.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv,
                         output int done_n, output int busy_n, output logic hold_ok,
                         output logic [9:0] res, output logic done_after);
      start = 1'b1; a = av; b = bv; ci = cv; sub = sv;
      done_n = -1; busy_n = 0; hold_ok = 1'b1; res = '0;
      @(posedge clk);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (n == 0) begin
            start = 1'b0; a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
         end
         if (busy) busy_n++;
         if (done) begin
            done_n = n;
            res = {ovf, co, s};
            break;
         end
         if ({ovf, co, s} !== last_res) hold_ok = 1'b0;
      end
      @(negedge clk);
      done_after = done;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, ovf, co, s} !== 11'd0)
         begin errors++; $display("FAIL reset_async got=%h want=000", {busy, done, ovf, co, s}); end
      start = 1'b1; a = 8'hFF; b = 8'hFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, ovf, co, s} !== 11'd0)
         begin errors++; $display("FAIL reset_held got=%h want=000", {busy, done, ovf, co, s}); end
      start = 1'b0;
      rst = 1'b0;
      last_res = '0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] ta [8] = '{8'h3C, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h55, 8'h01};
      logic [7:0] tb [8] = '{8'h25, 8'h01, 8'h01, 8'h80, 8'hFF, 8'h00, 8'hAA, 8'hFE};
      logic       tc [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      int dn, bn;
      logic hold, dafter;
      logic [9:0] res, exp;
      for (int i = 0; i < 8; i++) begin
         exp = model(ta[i], tb[i], tc[i], 1'b0);
         run_op(ta[i], tb[i], tc[i], 1'b0, dn, bn, hold, res, dafter);
         checks++;
         if (res !== exp)
            begin errors++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res, exp); end
         checks++;
         if (dn != W || bn != W)
            begin errors++; $display("FAIL directed_timing[%0d] done_at=%0d busy=%0d want=%0d", i, dn, bn, W); end
         checks++;
         if (!hold)
            begin errors++; $display("FAIL directed_hold[%0d] outputs changed during RUN want=%h", i, last_res); end
         checks++;
         if (dafter !== 1'b0)
            begin errors++; $display("FAIL directed_pulse[%0d] done_next=%b want=0", i, dafter); end
         last_res = exp;
      end
      // Fixed reference values for the first vectors, independent of the model.
      checks++;
      if (model(8'h3C, 8'h25, 1'b1, 1'b0) !== 10'h062 || model(8'h7F, 8'h01, 1'b0, 1'b0) !== 10'h280)
         begin errors++; $display("FAIL model_sanity got=%h want=062", model(8'h3C, 8'h25, 1'b1, 1'b0)); end
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_subtract();
      int dn, bn;
      logic hold, dafter;
      logic [9:0] res;
      run_op(8'h05, 8'h07, 1'b1, 1'b1, dn, bn, hold, res, dafter);
      checks++;
      if (res !== 10'h0FE) begin errors++; $display("FAIL sub_05_07 got=%h want=0fe", res); end
      last_res = 10'h0FE;
      run_op(8'h80, 8'h01, 1'b0, 1'b1, dn, bn, hold, res, dafter);
      checks++;
      if (res !== 10'h37F) begin errors++; $display("FAIL sub_80_01 got=%h want=37f", res); end
      last_res = 10'h37F;
   endtask
`endif

   task automatic test_random();
      int dn, bn;
      logic hold, dafter;
      logic [9:0] res, exp;
      logic [7:0] av, bv;
      logic cv, sv;
      for (int i = 0; i < 30; i++) begin
         av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         sv = 1'($urandom);
`else
         sv = 1'b0;
`endif
         exp = model(av, bv, cv, sv);
         run_op(av, bv, cv, sv, dn, bn, hold, res, dafter);
         checks++;
         if (res !== exp || dn != W)
            begin errors++; $display("FAIL random[%0d] a=%h b=%h ci=%b got=%h@%0d want=%h@%0d", i, av, bv, cv, res, dn, exp, W); end
         last_res = exp;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] oa [4];
      logic [7:0] ob [4];
      logic       oc [4];
      logic [9:0] exp [4];
      int k, last_cyc;
      for (int i = 0; i < 4; i++) begin
         oa[i] = 8'($urandom); ob[i] = 8'($urandom); oc[i] = 1'($urandom);
         exp[i] = model(oa[i], ob[i], oc[i], 1'b0);
      end
      k = 0; last_cyc = -1;
      start = 1'b1; a = oa[0]; b = ob[0]; ci = oc[0]; sub = 1'b0;
      for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
         @(negedge clk);
         if (done) begin
            checks++;
            if ({ovf, co, s} !== exp[k])
               begin errors++; $display("FAIL b2b_result[%0d] got=%h want=%h", k, {ovf, co, s}, exp[k]); end
            checks++;
            if (cyc - last_cyc != ((k == 0) ? W + 1 : W + 1))
               begin errors++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", k, cyc - last_cyc, W + 1); end
            last_cyc = cyc;
            k++;
            if (k < 4) begin
               a = oa[k]; b = ob[k]; ci = oc[k];
            end else begin
               start = 1'b0;
            end
         end else begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
         end
      end
      start = 1'b0;
      checks++;
      if (k != 4) begin errors++; $display("FAIL b2b_count got=%0d want=4", k); end
      last_res = exp[3];
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abort();
      int dn, bn;
      logic hold, dafter, saw_done;
      logic [9:0] res;
      start = 1'b1; a = 8'hAA; b = 8'h11; ci = 1'b0;
      @(posedge clk);
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, ovf, co, s} !== 11'd0)
         begin errors++; $display("FAIL abort_clear got=%h want=000", {busy, done, ovf, co, s}); end
      @(negedge clk);
      rst = 1'b0;
      last_res = '0;
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=1 want=0"); end
      run_op(8'h10, 8'h20, 1'b0, 1'b0, dn, bn, hold, res, dafter);
      checks++;
      if (res !== 10'h030 || dn != W)
         begin errors++; $display("FAIL abort_next got=%h@%0d want=030@%0d", res, dn, W); end
      last_res = 10'h030;
   endtask

   task automatic test_start_at_release();
      int dn, bn;
      logic hold, dafter;
      logic [9:0] res;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_res = '0;
      run_op(8'h81, 8'h81, 1'b1, 1'b0, dn, bn, hold, res, dafter);
      checks++;
      if (res !== 10'h303 || dn != W)
         begin errors++; $display("FAIL start_at_release got=%h@%0d want=303@%0d", res, dn, W); end
      last_res = 10'h303;
   endtask

   initial begin
      test_reset();
      test_directed();
`ifdef SERIAL_ADDER_SUB_EN
      test_subtract();
`endif
      test_random();
      test_back_to_back();
      test_abort();
      test_start_at_release();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A; sampled with start.
REQ-006 b  input  WIDTH  operand B; sampled with start.
REQ-007 ci  input  1  carry-in; sampled with start.
REQ-008 sub  input  1  subtract select, sampled with start; port present only when SERIAL_ADDER_SUB_EN is defined.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse, result just completed.
REQ-011 s  output  WIDTH  result sum.
REQ-012 co  output  1  result carry-out (unsigned carry).
REQ-013 ovf  output  1  result signed overflow.

Function
REQ-014 Block SHALL add bit-serially, LSB first, using one full-adder cell (sum = x^y^c, carry = x&y | c&(x^y)) and a carry register; no WIDTH-bit parallel adder.
REQ-015 FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-016 IDLE or DONE with start=1 at an edge: latch a, b, ci (and sub), carry register <= effective carry-in, bit counter <= 0, state <= RUN.
REQ-017 IDLE with start=0: remain IDLE. DONE with start=0: go IDLE.
REQ-018 RUN: each edge processes bit [counter], shifts sum bit into a WIDTH-bit working register at the MSB end, updates carry register, increments counter.
REQ-019 RUN: at the edge processing bit WIDTH-1, state <= DONE and s, co, ovf load the completed result in the same edge.
REQ-020 Latency: start sampled at edge E0 -> done=1 during the cycle after edge E(WIDTH), i.e. exactly WIDTH edges later; done high for exactly one cycle.
REQ-021 busy=1 exactly in RUN (WIDTH cycles); done=1 exactly in DONE.
REQ-022 start while in RUN SHALL be ignored; operation in progress unaffected; no queuing.
REQ-023 start in DONE SHALL be accepted (back-to-back throughput one result per WIDTH+1 cycles).
REQ-024 s, co, ovf SHALL hold the last completed result until the next completion; working-register changes never visible on s.
REQ-025 co = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-026 Operand inputs may change freely after the start edge without affecting the result.

Reset
REQ-027 rst=1 SHALL immediately (no clock) force state IDLE, busy=0, done=0, s=0, co=0, ovf=0, counter=0, carry register=0.
REQ-028 rst asserted mid-RUN SHALL abort the operation; no done pulse for it; first start after rst deasserts begins a fresh operation.
REQ-029 start coinciding with the edge on which rst deasserts SHALL be accepted normally.

Configuration
REQ-030 Macro SERIAL_ADDER_SUB_EN defined: sub port exists; sub=0 computes a+b+ci; sub=1 computes a-b as a + ~b + 1 (ci ignored), co=1 meaning no borrow, ovf per REQ-025.
REQ-031 Macro SERIAL_ADDER_SUB_EN undefined: no sub port, no inversion logic; always a+b+ci; timing identical.

Verification (WIDTH=8)
REQ-032 a=0x3C, b=0x25, ci=1, start one cycle -> busy 8 cycles, done pulse 8 edges after start, s=0x62, co=0, ovf=0.
REQ-033 a=0xFF, b=0x01, ci=0 -> s=0x00, co=1, ovf=0; a=0x7F, b=0x01, ci=0 -> s=0x80, co=0, ovf=1.
REQ-034 start held high continuously with new operands each DONE cycle -> done every 9 cycles, each result correct, start pulses during RUN ignored and operand changes after start do not alter result.
REQ-035 rst asserted asynchronously after 4 RUN cycles -> outputs zero immediately, no done pulse; next op a=0x10, b=0x20, ci=0 -> s=0x30.
REQ-036 With SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x07, ci=1 -> s=0xFE, co=0, ovf=0; a=0x80, b=0x01 -> s=0x7F, co=1, ovf=1.
